truth_table_sweeper: RTL and testbench
======================================

Name: truth_table_sweeper

Overview:
- Sequential stimulus-and-capture stage wrapped around a small combinational function under test (FUT).
- Upstream role: on request, walks the FUT inputs through every combination in ascending binary order.
- Downstream role: samples the FUT output for each combination into a truth-table register and counts minterms, so a lab design can be characterised in hardware rather than by a hand-written sweep.

Parameters:
- N_IN, 3: number of FUT inputs; legal range 1..6.
- SETTLE, 2: cycles each vector is held before the FUT output is sampled; legal minimum 1 (0 is illegal).

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  sweep request; level-sampled, acted on only in IDLE.
- f_in  input  1  FUT output, fed back combinationally from the FUT.
- vec_out  output  N_IN  FUT input vector; MSB drives the FUT's first input (a), LSB its last (c for N_IN=3).
- busy  output  1  high while a sweep is in progress (DRIVE or SAMPLE).
- done  output  1  one-cycle pulse when the sweep completes.
- table_out  output  2**N_IN  captured truth table; bit i = f_in sampled while vec_out == i.
- ones_cnt  output  N_IN+1  number of 1 bits in table_out.

Behaviour:
- Clock and reset:
  - Single clock domain.
  - rst is asynchronous and active-high.
  - Registered outputs only, apart from busy and done (see encodings below).
- Reset values:
  - state = IDLE, vec_out = 0, busy = 0, done = 0.
  - table_out = 0, ones_cnt = 0, settle counter = 0.
- States: IDLE, DRIVE, SAMPLE, DONE.
- IDLE:
  - start = 1 at a rising edge: go to DRIVE; vec_out <= 0; table_out <= 0; ones_cnt <= 0; settle counter <= 0.
  - start = 0: remain in IDLE; table_out and ones_cnt hold the previous sweep's result.
- DRIVE:
  - Settle counter increments each cycle.
  - When the counter equals SETTLE-1 at an edge, go to SAMPLE.
  - vec_out is stable throughout, so DRIVE lasts exactly SETTLE cycles.
- SAMPLE (one cycle):
  - At the edge: table_out[vec_out] <= f_in; ones_cnt <= ones_cnt + f_in.
  - If vec_out == 2**N_IN-1: go to DONE; vec_out holds.
  - Otherwise: vec_out <= vec_out+1; settle counter <= 0; go to DRIVE.
- DONE (one cycle):
  - done = 1, busy = 0.
  - Next edge returns to IDLE unconditionally, where start is evaluated again.
- Signal encodings:
  - busy = 1 exactly in DRIVE and SAMPLE.
  - done = 1 exactly in DONE.
  - Both are decoded from the registered state and are glitch-free.
- Latency:
  - Start accepted at edge k: busy high from after edge k.
  - Each vector takes SETTLE+1 cycles.
  - done is high after edge k + 2**N_IN*(SETTLE+1) for one cycle; for the defaults, after edge k+24.
- Boundary conditions:
  - start while busy: ignored, no restart.
  - start held high continuously: back-to-back sweeps, with one IDLE cycle between DONE and the next DRIVE.
  - vec_out wrap: never wraps; the sweep ends at all-ones.
  - ones_cnt: cannot overflow, because its width N_IN+1 holds 2**N_IN.
  - rst mid-sweep: immediate return to the reset values; the partial table is discarded; no done pulse.
  - f_in X/Z: no special handling; garbage in, garbage out.

Test Plan:
- Reset then idle: assert rst for 2 cycles, start = 0 for 10 cycles -> vec_out = 0, busy = 0, done = 0, table_out = 8'h00, ones_cnt = 0 throughout.
- Majority FUT: f = ab|bc|ac, pulse start for one cycle at edge k -> vec_out steps 0..7, each value held 3 cycles; done pulses exactly once after edge k+24; table_out = 8'hE8; ones_cnt = 4.
- XOR FUT: f = a^b^c -> table_out = 8'h96, ones_cnt = 4. Then constant-1 FUT on a second start -> table_out = 8'hFF, ones_cnt = 8; the old table is cleared at start.
- Start while busy: pulse start again at edge k+5 during the majority sweep -> no restart, done still after edge k+24, result unchanged.
- Reset mid-sweep: assert rst asynchronously between edges during vec_out = 4 -> outputs go to reset values immediately, without waiting for a clock edge; no done pulse; a new start gives a full, correct sweep.
- start held high, SETTLE = 1, N_IN = 2, FUT = a&b -> table_out = 4'b1000, ones_cnt = 1; done pulses every 10 cycles (8 sweep + DONE + IDLE).

Source files
------------

// File: rtl/truth_table_sweeper.sv
// Sweeps a combinational function under test through every input combination
// and captures its truth table and minterm count.
module truth_table_sweeper #(
  parameter int N_IN   = 3,
  parameter int SETTLE = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 f_in,
  output logic [N_IN-1:0]      vec_out,
  output logic                 busy,
  output logic                 done,
  output logic [2**N_IN-1:0]   table_out,
  output logic [N_IN:0]        ones_cnt,
  output logic [1:0]           state_dbg
);

  // start is a level request with no ready: it is accepted only in IDLE, busy
  // rises on the following cycle, and done pulses once when the result is final.

  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DRIVE  = 2'd1,
    S_SAMPLE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] settle_cnt;
  logic          last_vec;

  assign last_vec  = &vec_out;
  assign busy      = (state == S_DRIVE) || (state == S_SAMPLE);
  assign done      = (state == S_DONE);
  assign state_dbg = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (start) state_nxt = S_DRIVE;
      S_DRIVE:  if (settle_cnt == SETTLE_LAST) state_nxt = S_SAMPLE;
      S_SAMPLE: state_nxt = last_vec ? S_DONE : S_DRIVE;
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vec_out    <= '0;
      table_out  <= '0;
      ones_cnt   <= '0;
      settle_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            vec_out    <= '0;
            table_out  <= '0;
            ones_cnt   <= '0;
            settle_cnt <= '0;
          end
        end
        S_DRIVE: settle_cnt <= settle_cnt + 1'b1;
        S_SAMPLE: begin
          table_out[vec_out] <= f_in;
          ones_cnt           <= ones_cnt + (N_IN+1)'(f_in);
          // The sweep stops at all-ones; vec_out never wraps back to zero.
          if (!last_vec) begin
            vec_out    <= vec_out + 1'b1;
            settle_cnt <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper: default instance for sweeps and corner cases,
// small instance (N_IN=2, SETTLE=1) for back-to-back sweeps.
module tb_truth_table_sweeper;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       f_in;
  logic [2:0] vec_out;
  logic       busy, done;
  logic [7:0] table_out;
  logic [3:0] ones_cnt;
  logic [1:0] state_dbg;

  logic       start2 = 1'b0;
  logic       f_in2;
  logic [1:0] vec2;
  logic       busy2, done2;
  logic [3:0] table2;
  logic [2:0] ones2;
  logic [1:0] state2;

  int chk = 0;
  int err = 0;
  int mode = 0;

  logic [11:0] exp_q[$];

  typedef struct {
    int         mode;
    logic [7:0] exp_table;
    logic [3:0] exp_ones;
    bit         mid_start;
  } vec_t;

  vec_t vecs[6];

  always #5 clk = ~clk;

  truth_table_sweeper #(.N_IN(3), .SETTLE(2)) dut (
    .clk(clk), .rst(rst), .start(start), .f_in(f_in), .vec_out(vec_out),
    .busy(busy), .done(done), .table_out(table_out), .ones_cnt(ones_cnt),
    .state_dbg(state_dbg)
  );

  truth_table_sweeper #(.N_IN(2), .SETTLE(1)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .f_in(f_in2), .vec_out(vec2),
    .busy(busy2), .done(done2), .table_out(table2), .ones_cnt(ones2),
    .state_dbg(state2)
  );

  // FUT models: a = vec[2], b = vec[1], c = vec[0]
  function automatic logic fut(int m, logic [2:0] v);
    case (m)
      0:       return (v[2] & v[1]) | (v[1] & v[0]) | (v[2] & v[0]);
      1:       return v[2] ^ v[1] ^ v[0];
      2:       return 1'b1;
      3:       return v[2] & v[1] & v[0];
      default: return 1'b0;
    endcase
  endfunction

  assign f_in  = fut(mode, vec_out);
  assign f_in2 = vec2[1] & vec2[0];

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    chk++;
    if (act !== exp) begin
      err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: each done pulse of the main instance pops one expected result.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (exp_q.size() == 0) begin
        chk++;
        err++;
        $display("FAIL unexpected_done: got done=1 expected no pulse");
      end else begin
        logic [11:0] e;
        e = exp_q.pop_front();
        check("table_out", {24'd0, table_out}, {24'd0, e[11:4]});
        check("ones_cnt", {28'd0, ones_cnt}, {28'd0, e[3:0]});
      end
    end
  end

  task automatic run_sweep(int m, logic [7:0] et, logic [3:0] eo, bit mid);
    @(negedge clk);
    mode  = m;
    start = 1'b1;
    exp_q.push_back({et, eo});
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c <= 24; c++) begin
      if (c > 0) @(negedge clk);
      if (c == 0) begin
        check("cleared_table", {24'd0, table_out}, 32'd0);
        check("cleared_ones", {28'd0, ones_cnt}, 32'd0);
      end
      if (mid && c == 4) start = 1'b1;
      if (mid && c == 5) start = 1'b0;
      if (c < 24) begin
        check("vec_out", {29'd0, vec_out}, c / 3);
        check("busy", {31'd0, busy}, 32'd1);
        check("done_low", {31'd0, done}, 32'd0);
      end else begin
        check("done_latency", {31'd0, done}, 32'd1);
        check("busy_at_done", {31'd0, busy}, 32'd0);
        check("vec_hold", {29'd0, vec_out}, 32'd7);
      end
    end
    @(negedge clk);
    check("done_one_cycle", {31'd0, done}, 32'd0);
    check("idle_state", {30'd0, state_dbg}, 32'd0);
  endtask

  initial begin
    vecs[0] = '{0, 8'hE8, 4'd4, 1'b0};
    vecs[1] = '{1, 8'h96, 4'd4, 1'b0};
    vecs[2] = '{2, 8'hFF, 4'd8, 1'b0};
    vecs[3] = '{0, 8'hE8, 4'd4, 1'b1};
    vecs[4] = '{3, 8'h80, 4'd1, 1'b0};
    vecs[5] = '{4, 8'h00, 4'd0, 1'b0};

    // Reset then idle
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_vec", {29'd0, vec_out}, 32'd0);
      check("idle_busy", {31'd0, busy}, 32'd0);
      check("idle_done", {31'd0, done}, 32'd0);
      check("idle_table", {24'd0, table_out}, 32'd0);
      check("idle_ones", {28'd0, ones_cnt}, 32'd0);
    end

    for (int i = 0; i < 6; i++)
      run_sweep(vecs[i].mode, vecs[i].exp_table, vecs[i].exp_ones, vecs[i].mid_start);

    // Result holds in IDLE
    repeat (3) @(negedge clk);
    check("hold_table", {24'd0, table_out}, 32'h00);
    check("hold_queue_empty", exp_q.size(), 32'd0);

    // Reset mid-sweep while vec_out == 4
    @(negedge clk);
    mode  = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    begin
      int n;
      n = 0;
      while (vec_out != 3'd4 && n < 40) begin
        @(negedge clk);
        n++;
      end
      check("reach_vec4", {29'd0, vec_out}, 32'd4);
    end
    check("partial_ones", {28'd0, ones_cnt}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("arst_vec", {29'd0, vec_out}, 32'd0);
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_table", {24'd0, table_out}, 32'd0);
    check("arst_ones", {28'd0, ones_cnt}, 32'd0);
    check("arst_state", {30'd0, state_dbg}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    check("no_done_after_rst", exp_q.size(), 32'd0);
    run_sweep(0, 8'hE8, 4'd4, 1'b0);

    // Back-to-back sweeps on the small instance
    begin
      int last, ndone;
      last  = -1;
      ndone = 0;
      @(negedge clk);
      start2 = 1'b1;
      for (int cyc = 0; cyc <= 40; cyc++) begin
        @(negedge clk);
        if (done2) begin
          ndone++;
          check("b2b_table", {28'd0, table2}, 32'h8);
          check("b2b_ones", {29'd0, ones2}, 32'd1);
          if (last < 0) check("b2b_first_latency", cyc, 32'd8);
          else          check("b2b_period", cyc - last, 32'd10);
          last = cyc;
        end
      end
      check("b2b_done_count", ndone, 32'd4);
      start2 = 1'b0;
    end

    repeat (15) @(negedge clk);
    check("final_queue_empty", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", chk, err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
